sysctrl_gen: RTL and testbench
==============================

Name: sysctrl_gen

Overview:
Generic MCU-to-FPGA system control block for all cores, replacing the core-specific control block. It decodes the byte-serial command stream (start/strobe framed) from the MCU. It holds a parametrised bank of 8-bit user configuration slots addressed by the letters 'A'..'Z', drives LEDs and the RGB colour, and reports buttons. It latches edge-triggered interrupt channels with a mask, adds config readback, and pulses a per-slot change strobe.

Parameters:
CORE_ID, 8'h00, core identifier returned by CMD 0 byte 3
NUM_CFG, 26, number of config slots (1..26), slot n = letter 'A'+n
CFG_DEFAULT, {NUM_CFG{8'h00}}, NUM_CFG*8-bit reset value vector, slot n at bits [8n+7:8n]
NUM_INT, 8, interrupt channels (1..8); channel 0 is the coldboot notification
NUM_BTN, 2, button inputs

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
data_in_strobe  in  1  byte valid for one clk
data_in_start  in  1  qualifies strobe: byte is a command
data_in  in  8  command/parameter byte
data_out  out  8  response byte
int_out_n  out  1  low while any unmasked interrupt is pending
int_in  in  NUM_INT  interrupt sources, rising-edge sensitive; bit 0 unused
buttons  in  NUM_BTN  raw button levels
leds  out  2  MCU LEDs
color  out  24  RGB for ws2812
cfg  out  NUM_CFG*8  config slot values
cfg_changed  out  NUM_CFG  one-clk pulse per slot written

Behaviour:
- Reset values: data_out=0, leds=0, color=0, cfg=CFG_DEFAULT, cfg_changed=0.
- Reset values, continued: pending=1 (bit 0 only, coldboot), mask=all ones, state=IDLE. int_out_n is therefore 0 out of reset.
- Framing: a strobe with start loads the command and moves to state=1. Each further strobe increments state, saturating at 15. Strobes in IDLE without start are ignored. A new start aborts any command at any point.
- data_out is registered on the strobe cycle and valid from the next clk. It holds until the next strobe.
- CMD 0, status: state 1/2/3 returns 8'h5C / 8'h42 / CORE_ID.
- CMD 1, leds: state 1 loads data_in[1:0].
- CMD 2, colour: data bytes are bit-reversed. State 1 loads colour[15:8], state 2 loads [7:0], state 3 loads [23:16].
- CMD 3, buttons: every strobe returns the zero-extended buttons.
- CMD 4, write config: state 1 latches the id. State 2 writes data_in to the slot if id is in 'A' .. 'A'+NUM_CFG-1 and pulses cfg_changed[slot] the next clk. Other ids are ignored with no pulse. The pulse fires even if the value is unchanged. Bytes at state≥3 are ignored.
- CMD 5, interrupt ack: state 1 clears pending bits where data_in=1. Every strobe returns {pending}, zero-extended; the response is the pre-clear value on the state 1 byte.
- CMD 6, interrupt mask: state 1 loads mask[NUM_INT-1:0] from data_in. Every strobe returns the current mask.
- CMD 7, read config: state 1 latches the id and returns the slot value, or 8'h00 if out of range. Each later strobe returns the next slot (id+1), ending in 8'h00 past the last slot.
- Unknown commands return 8'hFF per strobe and have no side effects.
- Interrupts: int_in is registered once; a rising edge on bit k≥1 sets pending[k].
  - If an edge and an ack for the same bit occur in the same clk, set wins.
  - int_out_n = ~|(pending & mask), combinational from registers.
  - Coldboot bit 0 is set only by reset.
- A reset during a command returns to IDLE and discards the partial command.

Decomposition:
- Shared package sysctrl_pkg holds constants: the command codes CMD_STATUS..CMD_CFG_RD, the magic bytes 8'h5C/8'h42, CFG_ID_BASE="A", and the unknown-response value 8'hFF.
- One sub-module, sysctrl_irq: edge detect, pending, mask, int_out_n, with ack/mask write ports.
- The command decoder and config bank stay in the top level.

Test Plan:
- After reset with CORE_ID=8'h02: int_out_n=0. Send CMD 0 plus 3 bytes → data_out is 5C, 42, 02. Send CMD 5 with 8'h01 → read returns 8'h01, int_out_n then goes to 1.
- Send CMD 4, "C", 8'h03 with NUM_CFG=26 → cfg[23:16]=03 and cfg_changed[2] pulses exactly 1 clk. Send CMD 4, "[", 8'h55 → no change and no pulse.
- Send CMD 7, "Y" (NUM_CFG=26) → returns slot 24, then slot 25, then 00.
- Pulse int_in[3] low→high → int_out_n=0. Send CMD 6 with 8'hF7 → int_out_n=1 while pending stays set. Restore the mask, then ack 8'h08 → cleared. An edge coincident with the ack → remains pending.
- Send CMD 2 with bytes 8'h01, 8'h80, 8'hFF → color=24'hFF_80_01.
- Send CMD 4, "A", then start CMD 1 before the value byte, with value 8'h02 → cfg unchanged and leds=2'b10. Assert reset mid-CMD 2 → colour returns to 0 and state to IDLE.

Source files
------------

// File: rtl/sysctrl_pkg.sv
// Shared constants and helpers for the generic MCU system control block.
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS   = 8'h00;
  localparam logic [7:0] CMD_LEDS     = 8'h01;
  localparam logic [7:0] CMD_COLOR    = 8'h02;
  localparam logic [7:0] CMD_BUTTONS  = 8'h03;
  localparam logic [7:0] CMD_CFG_WR   = 8'h04;
  localparam logic [7:0] CMD_INT_ACK  = 8'h05;
  localparam logic [7:0] CMD_INT_MASK = 8'h06;
  localparam logic [7:0] CMD_CFG_RD   = 8'h07;

  localparam logic [7:0] MAGIC_0      = 8'h5C;
  localparam logic [7:0] MAGIC_1      = 8'h42;
  localparam logic [7:0] CFG_ID_BASE  = "A";
  localparam logic [7:0] RESP_UNKNOWN = 8'hFF;

  // Byte position within a command frame; saturates at ST_P15.
  typedef enum logic [3:0] {
    ST_IDLE, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_P6, ST_P7,
    ST_P8, ST_P9, ST_P10, ST_P11, ST_P12, ST_P13, ST_P14, ST_P15
  } state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // True when a letter id addresses config slot 'slot'.
  function automatic logic cfg_id_match(input logic [7:0] id, input int unsigned slot);
    return {24'd0, id} == ({24'd0, CFG_ID_BASE} + slot);
  endfunction

endpackage

// File: rtl/sysctrl_irq.sv
// Interrupt latch: rising-edge capture, pending/mask registers, active-low summary.
module sysctrl_irq
  import sysctrl_pkg::*;
#(
  parameter int unsigned NUM_INT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               ack_en,
  input  logic [NUM_INT-1:0] ack_bits,
  input  logic               mask_wr,
  input  logic [NUM_INT-1:0] mask_data,
  output logic [NUM_INT-1:0] pending,
  output logic [NUM_INT-1:0] mask,
  output logic               int_out_n
);

  // Bit 0 is the coldboot flag; only reset sets it.
  localparam logic [NUM_INT-1:0] EDGE_EN = ~NUM_INT'(1);

  logic [NUM_INT-1:0] int_q;
  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] clr;

  // Edge detect against the registered copy; ack only when requested.
  always_comb begin
    rise = int_in & ~int_q & EDGE_EN;
    clr  = ack_en ? ack_bits : '0;
  end

  // Pending/mask state; a coincident edge beats an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_q   <= int_in;
      pending <= NUM_INT'(1);
      mask    <= '1;
    end else begin
      int_q   <= int_in;
      pending <= (pending & ~clr) | rise;
      if (mask_wr) mask <= mask_data;
    end
  end

  assign int_out_n = ~|(pending & mask);

endmodule

// File: rtl/sysctrl_gen.sv
// Generic MCU-to-FPGA system control: command decoder, config bank, LEDs, colour, IRQs.
module sysctrl_gen
  import sysctrl_pkg::*;
#(
  parameter logic [7:0]           CORE_ID     = 8'h00,
  parameter int unsigned          NUM_CFG     = 26,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULT = '0,
  parameter int unsigned          NUM_INT     = 8,
  parameter int unsigned          NUM_BTN     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in_strobe,
  input  logic                 data_in_start,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 int_out_n,
  input  logic [NUM_INT-1:0]   int_in,
  input  logic [NUM_BTN-1:0]   buttons,
  output logic [1:0]           leds,
  output logic [23:0]          color,
  output logic [NUM_CFG*8-1:0] cfg,
  output logic [NUM_CFG-1:0]   cfg_changed
);

  state_t             state, state_nxt;
  logic [7:0]         cmd;
  logic [7:0]         wr_id;
  logic [7:0]         rd_ptr;
  logic [7:0]         rd_sel;
  logic [7:0]         rd_val;
  logic               param_stb;
  logic               ack_en;
  logic               mask_wr;
  logic [NUM_INT-1:0] pending;
  logic [NUM_INT-1:0] mask;

  assign param_stb = data_in_strobe && !data_in_start && (state != ST_IDLE);
  assign ack_en    = param_stb && (cmd == CMD_INT_ACK)  && (state == ST_P1);
  assign mask_wr   = param_stb && (cmd == CMD_INT_MASK) && (state == ST_P1);

  sysctrl_irq #(.NUM_INT(NUM_INT)) u_irq (
    .clk       (clk),
    .reset     (reset),
    .int_in    (int_in),
    .ack_en    (ack_en),
    .ack_bits  (data_in[NUM_INT-1:0]),
    .mask_wr   (mask_wr),
    .mask_data (data_in[NUM_INT-1:0]),
    .pending   (pending),
    .mask      (mask),
    .int_out_n (int_out_n)
  );

  // Frame position register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Start restarts a frame; other strobes advance it until saturation.
  always_comb begin
    state_nxt = state;
    if (data_in_strobe) begin
      if (data_in_start)
        state_nxt = ST_P1;
      else if (state != ST_IDLE && state != ST_P15)
        state_nxt = state_t'(4'(state) + 4'd1);
    end
  end

  // Config readback mux: first byte addresses directly, later bytes walk rd_ptr.
  always_comb begin
    rd_sel = (state == ST_P1) ? data_in : rd_ptr;
    rd_val = '0;
    for (int unsigned n = 0; n < NUM_CFG; n++)
      if (cfg_id_match(rd_sel, n)) rd_val = cfg[8*n +: 8];
  end

  // Command execution and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd         <= '0;
      wr_id       <= '0;
      rd_ptr      <= '0;
      data_out    <= '0;
      leds        <= '0;
      color       <= '0;
      cfg         <= CFG_DEFAULT;
      cfg_changed <= '0;
    end else begin
      cfg_changed <= '0;
      if (data_in_strobe && data_in_start) begin
        cmd <= data_in;
      end else if (param_stb) begin
        case (cmd)
          CMD_STATUS: begin
            case (state)
              ST_P1:   data_out <= MAGIC_0;
              ST_P2:   data_out <= MAGIC_1;
              ST_P3:   data_out <= CORE_ID;
              default: ;
            endcase
          end
          CMD_LEDS: if (state == ST_P1) leds <= data_in[1:0];
          CMD_COLOR: begin
            case (state)
              ST_P1:   color[15:8]  <= bitrev8(data_in);
              ST_P2:   color[7:0]   <= bitrev8(data_in);
              ST_P3:   color[23:16] <= bitrev8(data_in);
              default: ;
            endcase
          end
          CMD_BUTTONS: data_out <= 8'(buttons);
          CMD_CFG_WR: begin
            if (state == ST_P1) begin
              wr_id <= data_in;
            end else if (state == ST_P2) begin
              for (int unsigned n = 0; n < NUM_CFG; n++) begin
                if (cfg_id_match(wr_id, n)) begin
                  cfg[8*n +: 8]  <= data_in;
                  cfg_changed[n] <= 1'b1;
                end
              end
            end
          end
          CMD_INT_ACK:  data_out <= 8'(pending);
          CMD_INT_MASK: data_out <= 8'(mask);
          CMD_CFG_RD: begin
            data_out <= rd_val;
            // Pointer stops at 8'hFF so a long read never wraps back into 'A'.
            rd_ptr   <= (rd_sel == 8'hFF) ? rd_sel : rd_sel + 8'd1;
          end
          default: data_out <= RESP_UNKNOWN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sysctrl_gen.sv
// Self-checking bench for sysctrl_gen: vector table plus hand-written sequences.
module tb_sysctrl_gen;
  localparam int unsigned NUM_CFG = 26;
  localparam int unsigned NUM_INT = 8;
  localparam int unsigned NUM_BTN = 2;
  localparam logic [NUM_CFG*8-1:0] CFG_DEF = {8'hAA, 8'h99, 192'h0};

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 data_in_strobe;
  logic                 data_in_start;
  logic [7:0]           data_in;
  logic [7:0]           data_out;
  logic                 int_out_n;
  logic [NUM_INT-1:0]   int_in;
  logic [NUM_BTN-1:0]   buttons;
  logic [1:0]           leds;
  logic [23:0]          color;
  logic [NUM_CFG*8-1:0] cfg;
  logic [NUM_CFG-1:0]   cfg_changed;

  sysctrl_gen #(
    .CORE_ID     (8'h02),
    .NUM_CFG     (NUM_CFG),
    .CFG_DEFAULT (CFG_DEF),
    .NUM_INT     (NUM_INT),
    .NUM_BTN     (NUM_BTN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .int_out_n      (int_out_n),
    .int_in         (int_in),
    .buttons        (buttons),
    .leds           (leds),
    .color          (color),
    .cfg            (cfg),
    .cfg_changed    (cfg_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    int unsigned n;
    logic [7:0]  b [3];
    logic [7:0]  r [3];
    string       name;
  } vec_t;

  vec_t                 vecs [7];
  logic [7:0]           sb_q [$];
  int                   tests = 0;
  int                   fails = 0;
  logic [NUM_CFG*8-1:0] cfg_exp;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One strobe; when chk is set the expected response goes through the scoreboard.
  task automatic send(input logic start, input logic [7:0] b, input logic chk,
                      input logic [7:0] exp, input string name);
    logic [7:0] e;
    @(negedge clk);
    data_in_strobe = 1'b1;
    data_in_start  = start;
    data_in        = b;
    if (chk) sb_q.push_back(exp);
    @(negedge clk);
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    if (chk) begin
      e = sb_q.pop_front();
      check(name, {248'd0, data_out}, {248'd0, e});
    end
  endtask

  task automatic set_vec(input int idx, input logic [7:0] c, input int unsigned n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                         input string name);
    vecs[idx].cmd  = c;
    vecs[idx].n    = n;
    vecs[idx].b[0] = b0; vecs[idx].b[1] = b1; vecs[idx].b[2] = b2;
    vecs[idx].r[0] = r0; vecs[idx].r[1] = r1; vecs[idx].r[2] = r2;
    vecs[idx].name = name;
  endtask

  initial begin
    reset = 1'b1; data_in_strobe = 1'b0; data_in_start = 1'b0; data_in = '0;
    int_in = '0; buttons = 2'b10;
    cfg_exp = CFG_DEF;

    set_vec(0, 8'h00, 3, 8'h00, 8'h00, 8'h00, 8'h5C, 8'h42, 8'h02, "status");
    set_vec(1, 8'h03, 2, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00, "buttons");
    set_vec(2, 8'h06, 2, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, "mask_rd");
    set_vec(3, 8'h07, 3, "Y",   8'h00, 8'h00, 8'h99, 8'hAA, 8'h00, "cfg_rd_Y");
    set_vec(4, 8'h09, 2, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hFF, 8'h00, "unknown");
    set_vec(5, 8'h07, 1, "@",   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "cfg_rd_oob");
    set_vec(6, 8'h05, 1, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, "ack_coldboot");

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data_out", {248'd0, data_out}, 256'd0);
    check("rst_leds", {254'd0, leds}, 256'd0);
    check("rst_color", {232'd0, color}, 256'd0);
    check("rst_cfg", {48'd0, cfg}, {48'd0, CFG_DEF});
    check("rst_cfg_changed", {230'd0, cfg_changed}, 256'd0);
    check("rst_int_out_n", {255'd0, int_out_n}, 256'd0);

    for (int i = 0; i < 7; i++) begin
      send(1'b1, vecs[i].cmd, 1'b0, 8'h00, "");
      for (int unsigned j = 0; j < vecs[i].n; j++)
        send(1'b0, vecs[i].b[j], 1'b1, vecs[i].r[j], vecs[i].name);
    end
    check("int_out_n_after_ack", {255'd0, int_out_n}, 256'd1);

    // Interrupt edge, masking, ack, and ack coincident with a new edge.
    @(negedge clk); int_in = 8'h08;
    @(negedge clk);
    check("irq3_edge", {255'd0, int_out_n}, 256'd0);
    send(1'b1, 8'h06, 1'b0, 8'h00, "");
    send(1'b0, 8'hF7, 1'b1, 8'hFF, "mask_wr_old");
    check("irq3_masked", {255'd0, int_out_n}, 256'd1);
    send(1'b1, 8'h05, 1'b0, 8'h00, "");
    send(1'b0, 8'h00, 1'b1, 8'h08, "pending_kept");
    send(1'b1, 8'h06, 1'b0, 8'h00, "");
    send(1'b0, 8'hFF, 1'b1, 8'hF7, "mask_restore");
    check("irq3_unmasked", {255'd0, int_out_n}, 256'd0);
    send(1'b1, 8'h05, 1'b0, 8'h00, "");
    send(1'b0, 8'h08, 1'b1, 8'h08, "ack3");
    check("irq3_cleared", {255'd0, int_out_n}, 256'd1);
    @(negedge clk); int_in = 8'h00;
    repeat (2) @(negedge clk);
    send(1'b1, 8'h05, 1'b0, 8'h00, "");
    @(negedge clk);
    data_in_strobe = 1'b1; data_in_start = 1'b0; data_in = 8'h08; int_in = 8'h08;
    @(negedge clk);
    data_in_strobe = 1'b0;
    check("ack_coincident_resp", {248'd0, data_out}, 256'd0);
    check("ack_coincident_irq", {255'd0, int_out_n}, 256'd0);
    send(1'b1, 8'h05, 1'b0, 8'h00, "");
    send(1'b0, 8'h00, 1'b1, 8'h08, "set_wins");

    // Colour bytes are bit-reversed and land in G, B, R order.
    send(1'b1, 8'h02, 1'b0, 8'h00, "");
    send(1'b0, 8'h01, 1'b0, 8'h00, "");
    send(1'b0, 8'h80, 1'b0, 8'h00, "");
    send(1'b0, 8'hFF, 1'b0, 8'h00, "");
    check("color", {232'd0, color}, {232'd0, 24'hFF8001});

    // Config write with one-clock change pulse, then an out-of-range id.
    send(1'b1, 8'h04, 1'b0, 8'h00, "");
    send(1'b0, "C", 1'b0, 8'h00, "");
    send(1'b0, 8'h03, 1'b0, 8'h00, "");
    cfg_exp[23:16] = 8'h03;
    check("cfg_C", {48'd0, cfg}, {48'd0, cfg_exp});
    check("cfg_changed_C", {230'd0, cfg_changed}, {230'd0, 26'd4});
    @(negedge clk);
    check("cfg_changed_C_end", {230'd0, cfg_changed}, 256'd0);
    send(1'b1, 8'h04, 1'b0, 8'h00, "");
    send(1'b0, "C", 1'b0, 8'h00, "");
    send(1'b0, 8'h03, 1'b0, 8'h00, "");
    check("cfg_changed_same", {230'd0, cfg_changed}, {230'd0, 26'd4});
    send(1'b1, 8'h04, 1'b0, 8'h00, "");
    send(1'b0, "[", 1'b0, 8'h00, "");
    send(1'b0, 8'h55, 1'b0, 8'h00, "");
    check("cfg_oob", {48'd0, cfg}, {48'd0, cfg_exp});
    check("cfg_changed_oob", {230'd0, cfg_changed}, 256'd0);

    // A new start abandons a half-sent config write.
    send(1'b1, 8'h04, 1'b0, 8'h00, "");
    send(1'b0, "A", 1'b0, 8'h00, "");
    send(1'b1, 8'h01, 1'b0, 8'h00, "");
    send(1'b0, 8'h02, 1'b0, 8'h00, "");
    check("abort_cfg", {48'd0, cfg}, {48'd0, cfg_exp});
    check("abort_cfg_changed", {230'd0, cfg_changed}, 256'd0);
    check("abort_leds", {254'd0, leds}, {254'd0, 2'b10});

    // Reset in the middle of a colour command.
    send(1'b1, 8'h02, 1'b0, 8'h00, "");
    send(1'b0, 8'h0F, 1'b0, 8'h00, "");
    check("color_partial", {232'd0, color}, {232'd0, 24'hFFF001});
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_color", {232'd0, color}, 256'd0);
    check("midrst_data_out", {248'd0, data_out}, 256'd0);
    check("midrst_cfg", {48'd0, cfg}, {48'd0, CFG_DEF});
    check("midrst_int_out_n", {255'd0, int_out_n}, 256'd0);
    send(1'b0, 8'h33, 1'b0, 8'h00, "");
    check("midrst_idle", {232'd0, color}, 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
